shift_divider: RTL and testbench

//  Multi-cycle signed integer divider (radix-2 restoring, one quotient bit per cycle).

---
 rtl/shift_divider.sv | 117 +++++++++++
 tb/tb_shift_divider.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shift_divider.sv
// Multi-cycle signed restoring divider: one quotient bit per enabled cycle,
// with sign fix-up and divide-by-zero handling before the one-cycle ready pulse.
module shift_divider #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] jia,
  input  logic [DATA_WIDTH-1:0] yi,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero,
  output logic                  busy,
  output logic                  ready,
  output logic [1:0]            state_dbg
);

  // Handshake: valid is sampled only in IDLE with en=1 (that edge is the
  // accept); ready is a one-cycle pulse marking new results; no back-pressure.

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t          state;
  logic [W:0]      rem;
  logic [W-1:0]    dvd;
  logic [W-1:0]    dvs;
  logic            sign_q;
  logic            sign_r;
  logic            zero;
  logic [CW-1:0]   cnt;

  logic [W-1:0]    jia_mag;
  logic [W-1:0]    yi_mag;
  logic [W:0]      rem_sh;
  logic [W:0]      rem_diff;
  logic            fits;
  logic [W-1:0]    q_signed;
  logic [W-1:0]    r_signed;

  // Magnitudes are unsigned W-bit, so |-2^(W-1)| is represented exactly.
  always_comb begin
    jia_mag  = jia[W-1] ? (~jia + 1'b1) : jia;
    yi_mag   = yi[W-1]  ? (~yi + 1'b1)  : yi;
    rem_sh   = {rem[W-1:0], dvd[W-1]};
    rem_diff = rem_sh - {1'b0, dvs};
    fits     = (rem_sh >= {1'b0, dvs});
    q_signed = sign_q ? (~dvd + 1'b1) : dvd;
    r_signed = sign_r ? (~rem[W-1:0] + 1'b1) : rem[W-1:0];
  end

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero        <= 1'b0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      ready       <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (valid) begin
            rem    <= '0;
            dvd    <= jia_mag;
            dvs    <= yi_mag;
            sign_q <= jia[W-1] ^ yi[W-1];
            sign_r <= jia[W-1];
            zero   <= (yi == '0);
            busy   <= 1'b1;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          // dvd shifts out dividend bits at the top and collects quotient bits at the bottom.
          rem <= fits ? rem_diff : rem_sh;
          dvd <= {dvd[W-2:0], fits};
          if (cnt == CW'(W - 1)) begin
            state <= SIGN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SIGN: begin
          // With a zero divisor every step "fits" and rem ends up holding |jia|,
          // so the sign fix-up restores jia itself as the remainder.
          quotient    <= zero ? '1 : q_signed;
          remainder   <= r_signed;
          div_by_zero <= zero;
          ready       <= 1'b1;
          busy        <= 1'b0;
          state       <= DONE;
        end
        DONE: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_divider.sv
// Scoreboard bench for shift_divider: expected results queued at issue,
// popped and compared when ready pulses; latency checked per operation.
module tb_shift_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         valid;
  logic [W-1:0] jia;
  logic [W-1:0] yi;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;
  logic         ready;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W:0] exp_q[$];

  shift_divider #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .valid       (valid),
    .jia         (jia),
    .yi          (yi),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .ready       (ready),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {dbz, quotient, remainder}, C-style truncating division.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int ai;
    int bi;
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == '0) begin
      return {1'b1, {W{1'b1}}, a};
    end
    ai = $signed(a);
    bi = $signed(b);
    q  = W'(ai / bi);
    r  = W'(ai % bi);
    return {1'b0, q, r};
  endfunction

  // Issue one operation at an IDLE negedge and wait (bounded) for its result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int exp_lat,
                        input bit stall, input bit noise, input bit hold);
    int cyc;
    bit got;
    logic [2*W:0] exp;
    jia   = a;
    yi    = b;
    valid = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    cyc = 0;
    got = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        jia = W'($urandom);
        yi  = W'($urandom);
      end else begin
        valid = 1'b0;
      end
      if (noise) begin
        valid = (cyc >= 2 && cyc <= 6);
        jia   = 16'd20;
        yi    = 16'd3;
      end
      if (stall && cyc == 5)  en = 1'b0;
      if (stall && cyc == 10) en = 1'b1;
      if (cyc == 1) check("busy_start", 32'(busy), 32'd1);
      if (ready) begin
        got = 1;
        check("latency", cyc, exp_lat);
        check("busy_done", 32'(busy), 32'd0);
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check("quotient", 32'(quotient), 32'(exp[2*W-1:W]));
          check("remainder", 32'(remainder), 32'(exp[W-1:0]));
          check("div_by_zero", 32'(div_by_zero), 32'(exp[2*W]));
        end else begin
          check("unexpected_ready", 32'd1, 32'd0);
        end
      end
    end
    if (!got) begin
      check("timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(negedge clk);
    check("ready_pulse", 32'(ready), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    valid = 1'b0;
    jia   = '0;
    yi    = '0;
    repeat (2) @(negedge clk);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'd100, 16'd7, 18, 0, 0, 0);
    run_op(-16'sd100, 16'd7, 18, 0, 0, 0);
    run_op(16'd100, -16'sd7, 18, 0, 0, 0);
    run_op(-16'sd100, -16'sd7, 18, 0, 0, 0);
    run_op(16'h8000, 16'hFFFF, 18, 0, 0, 0);
    run_op(16'd0, 16'd5, 18, 0, 0, 0);
    run_op(16'd7, 16'd9, 18, 0, 0, 0);
    run_op(16'h8000, 16'd0, 18, 0, 0, 0);
    run_op(16'd5, 16'd0, 18, 0, 0, 0);
    run_op(16'd9, 16'd3, 18, 0, 0, 0);

    // Valid pulses during busy must not queue a second operation.
    run_op(16'd100, 16'd7, 18, 0, 1, 0);
    valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("no_extra_ready", 32'(ready), 32'd0);
    end

    run_op(16'd100, 16'd7, 23, 1, 0, 0);
    check("stall_hold_q", 32'(quotient), 32'd14);

    // Asynchronous reset in the middle of CALC discards the operation.
    jia   = 16'd1234;
    yi    = 16'd5;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(16'd1234, 16'd5, 18, 0, 0, 0);

    // Back-to-back random operations with valid held high throughout.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = W'($urandom);
      if (i % 10 == 3) b = '0;
      if (i % 10 == 6) a = 16'h8000;
      if (i % 10 == 7) b = 16'hFFFF;
      if (i % 10 == 8) b = W'($urandom_range(1, 15));
      run_op(a, b, 18, 0, 0, 1);
    end
    valid = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
